// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tomasulo_pkg
// Brief   : Shared widths, station tags and CDB requester indices.
// Revision: 1.0
// ============================================================================
package tomasulo_pkg;

  localparam int TAG_W  = 4;
  localparam int ROB_W  = 2;
  localparam int DATA_W = 64;

  localparam logic [TAG_W-1:0] notag  = 4'd0;
  localparam logic [TAG_W-1:0] add_1  = 4'd1;
  localparam logic [TAG_W-1:0] add_2  = 4'd2;
  localparam logic [TAG_W-1:0] add_3  = 4'd3;
  localparam logic [TAG_W-1:0] mult_1 = 4'd4;
  localparam logic [TAG_W-1:0] mult_2 = 4'd5;
  localparam logic [TAG_W-1:0] ld_1   = 4'd6;
  localparam logic [TAG_W-1:0] ld_2   = 4'd7;
  localparam logic [TAG_W-1:0] ld_3   = 4'd8;
  localparam logic [TAG_W-1:0] st_1   = 4'd9;
  localparam logic [TAG_W-1:0] st_2   = 4'd10;

  localparam int REQ_ADD  = 0;
  localparam int REQ_MULT = 1;
  localparam int REQ_LD   = 2;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotate-priority picker; searches from last+1 upward.
// Revision: 1.0
// ============================================================================
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin : p_pick
    int   j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!found && eligible[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Brief   : Round-robin common-data-bus arbiter with registered broadcast.
// Revision: 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = tomasulo_pkg::TAG_W,
  parameter int DATA_W  = tomasulo_pkg::DATA_W,
  parameter int ROB_W   = tomasulo_pkg::ROB_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      cdb_stall,
  input  logic                      flush,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_id,
  output logic [ROB_W-1:0]          cdb_rob,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [CNT_W-1:0]          bcast_count
);

  import tomasulo_pkg::*;

  localparam int               IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_block;
  logic               w_fire;
  logic [TAG_W-1:0]   w_sel_tag;
  logic [ROB_W-1:0]   w_sel_rob;
  logic [DATA_W-1:0]  w_sel_data;

  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_count;
  logic               r_valid;
  logic [TAG_W-1:0]   r_id;
  logic [ROB_W-1:0]   r_rob;
  logic [DATA_W-1:0]  r_data;

  // A result carrying the null tag has no station to free, so it never wins.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign w_elig[gi] = req[gi] && (req_tag[gi*TAG_W +: TAG_W] != TAG_W'(notag));
    end
  endgenerate

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible  (w_elig),
    .last      (r_last),
    .grant     (w_pick_grant),
    .grant_idx (w_pick_idx)
  );

  assign w_block = reset | flush | cdb_stall;
  assign grant   = w_block ? '0 : w_pick_grant;
  assign w_fire  = |grant;

  always_comb begin
    w_sel_tag  = '0;
    w_sel_rob  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        w_sel_tag  = req_tag[i*TAG_W +: TAG_W];
        w_sel_rob  = req_rob[i*ROB_W +: ROB_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Idle cycles drive zeros so consumers never capture a stale tag twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_rob   <= '0;
      r_data  <= '0;
      r_last  <= c_last_rst;
      r_count <= '0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_id    <= w_sel_tag;
      r_rob   <= w_sel_rob;
      r_data  <= w_sel_data;
      r_last  <= w_pick_idx;
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_rob   <= '0;
      r_data  <= '0;
    end
  end

  assign cdb_valid   = r_valid;
  assign cdb_id      = r_id;
  assign cdb_rob     = r_rob;
  assign cdb_data    = r_data;
  assign bcast_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Directed plus randomized checks of cdb_arbiter against a reference model.
// Revision: 1.0
// ============================================================================
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int N  = 3;
  localparam int TW = 4;
  localparam int DW = 64;
  localparam int RW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*TW-1:0] req_tag;
  logic [N*RW-1:0] req_rob;
  logic [N*DW-1:0] req_data;
  logic            cdb_stall;
  logic            flush;
  logic [N-1:0]    grant;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_id;
  logic [RW-1:0]   cdb_rob;
  logic [DW-1:0]   cdb_data;
  logic [CW-1:0]   bcast_count;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .ROB_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_tag(req_tag), .req_rob(req_rob),
    .req_data(req_data), .cdb_stall(cdb_stall), .flush(flush), .grant(grant),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .bcast_count(bcast_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: who won last, how many broadcasts, what the bus should show.
  int          m_last;
  int unsigned m_count;
  logic        m_valid;
  logic [TW-1:0] m_id;
  logic [RW-1:0] m_rob;
  logic [DW-1:0] m_data;
  int          granted_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] el, input int last);
    for (int k = 1; k <= N; k++)
      if (el[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [TW-1:0] t,
                         input logic [RW-1:0] r, input logic [DW-1:0] d);
    req[i]               = v;
    req_tag[i*TW +: TW]  = t;
    req_rob[i*RW +: RW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  // Inputs are expected to be stable; checks grant now and the bus after the edge.
  task automatic tick(input bit check_out);
    logic [N-1:0] el;
    logic [N-1:0] exp_g;
    int g;
    #1;
    for (int i = 0; i < N; i++) el[i] = req[i] && (req_tag[i*TW +: TW] != 0);
    g = -1;
    exp_g = '0;
    if (!reset && !flush && !cdb_stall) g = model_pick(el, m_last);
    if (g >= 0) exp_g[g] = 1'b1;
    if (check_out) chk("grant", 64'(grant), 64'(exp_g));
    granted_idx = g;
    if (reset) begin
      m_last = N - 1; m_count = 0;
      m_valid = 0; m_id = 0; m_rob = 0; m_data = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_id    = req_tag[g*TW +: TW];
      m_rob   = req_rob[g*RW +: RW];
      m_data  = req_data[g*DW +: DW];
      m_last  = g;
      m_count = (m_count + 1) % 65536;
    end else begin
      m_valid = 0; m_id = 0; m_rob = 0; m_data = 0;
    end
    @(posedge clk);
    #1;
    if (check_out) begin
      chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
      chk("cdb_id", 64'(cdb_id), 64'(m_id));
      chk("cdb_rob", 64'(cdb_rob), 64'(m_rob));
      chk("cdb_data", cdb_data, m_data);
      chk("bcast_count", 64'(bcast_count), 64'(m_count));
    end
  endtask

  task automatic rand_req(input int i);
    logic [TW-1:0] t;
    t = ($urandom_range(0, 7) == 0) ? 4'd0 : TW'($urandom_range(1, 10));
    set_req(i, ($urandom_range(0, 1) == 1), t, RW'($urandom),
            {$urandom, $urandom});
  endtask

  logic [TW-1:0] fair_ids [3];

  initial begin
    m_last = N - 1; m_count = 0; m_valid = 0; m_id = 0; m_rob = 0; m_data = 0;
    granted_idx = -1;
    reset = 1; flush = 0; cdb_stall = 0;
    req = '0; req_tag = '0; req_rob = '0; req_data = '0;

    // Reset with all requesting
    set_req(REQ_ADD,  1, add_1,  0, 64'h11);
    set_req(REQ_MULT, 1, mult_1, 1, 64'h22);
    set_req(REQ_LD,   1, ld_1,   2, 64'h33);
    tick(1);
    tick(1);
    chk("rst_count", 64'(bcast_count), 64'd0);

    // Single requester
    reset = 0;
    req = '0;
    set_req(REQ_MULT, 1, mult_1, 1, 64'hDEAD);
    tick(1);
    chk("single_id", 64'(cdb_id), 64'd4);
    chk("single_data", cdb_data, 64'hDEAD);
    chk("single_count", 64'(bcast_count), 64'd1);
    req = '0;
    tick(1);

    // Fairness from a fresh reset
    reset = 1; tick(1); reset = 0;
    fair_ids[0] = add_1; fair_ids[1] = mult_1; fair_ids[2] = ld_1;
    set_req(REQ_ADD,  1, add_1,  0, 64'hA);
    set_req(REQ_MULT, 1, mult_1, 1, 64'hB);
    set_req(REQ_LD,   1, ld_1,   2, 64'hC);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("fair_id", 64'(cdb_id), 64'(fair_ids[k % 3]));
    end

    // Stall then flush, rotation resumes at requester 0
    reset = 1; tick(1); reset = 0;
    req = '0;
    set_req(REQ_ADD,  1, add_2,  3, 64'h100);
    set_req(REQ_MULT, 1, mult_2, 2, 64'h200);
    cdb_stall = 1; tick(1); tick(1); cdb_stall = 0;
    flush = 1; tick(1); flush = 0;
    chk("flush_idle", 64'(cdb_id), 64'd0);
    tick(1);
    chk("resume_id", 64'(cdb_id), 64'(add_2));

    // Tag 0 is never granted
    req = '0;
    set_req(REQ_ADD, 1, notag, 1, 64'h55);
    for (int k = 0; k < 4; k++) tick(1);

    // Counter wrap
    reset = 1; tick(1); reset = 0;
    set_req(REQ_LD, 1, ld_2, 1, 64'h77);
    for (int k = 0; k < 65535; k++) tick(0);
    chk("pre_wrap", 64'(bcast_count), 64'hFFFF);
    tick(1);
    chk("wrap", 64'(bcast_count), 64'd0);

    // Randomized traffic under the handshake rules
    req = '0;
    for (int i = 0; i < N; i++) rand_req(i);
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      cdb_stall = ($urandom_range(0, 4) == 0);
      tick(1);
      for (int i = 0; i < N; i++)
        if (granted_idx == i || reset || flush || !req[i] || req_tag[i*TW +: TW] == 0)
          rand_req(i);
    end
    reset = 0; flush = 0; cdb_stall = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB) in the Tomasulo core. It takes completed results from the functional-unit reservation-station groups (adder, multiplier, load) and grants one per cycle. The winner's tag, ROB slot and data are registered and broadcast on the CDB, which feeds the reservation-station operand capture, the station-free logic and the ROB.

## Interface
- NUM_REQ, 3, number of requesters; index 0 = adder, 1 = multiplier, 2 = load
- TAG_W, 4, reservation-station tag width; tag 0 = notag
- DATA_W, 64, result width
- ROB_W, 2, ROB slot index width
- CNT_W, 16, broadcast counter width
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester result-ready (the group's ready_to_write)
- req_tag  in  NUM_REQ*TAG_W  flat; slice i = issuing station tag (cdb_write_id)
- req_rob  in  NUM_REQ*ROB_W  flat; slice i = destination ROB slot
- req_data  in  NUM_REQ*DATA_W  flat; slice i = result value
- cdb_stall  in  1  ROB cannot accept a broadcast this cycle
- flush  in  1  mispredict squash
- grant  out  NUM_REQ  one-hot or zero; combinational
- cdb_valid  out  1  broadcast valid this cycle
- cdb_id  out  TAG_W  broadcast tag
- cdb_rob  out  ROB_W  broadcast ROB slot
- cdb_data  out  DATA_W  broadcast value
- bcast_count  out  CNT_W  total broadcasts since reset, wraps

## Operation
- Eligibility: requester i is eligible when req[i]=1 and req_tag slice i != 0. A request carrying tag 0 is never granted.
- Pick: among eligible requesters, choose the first one found searching from last+1 upward, modulo NUM_REQ. `last` is the index of the most recent grant.
- grant is forced to zero when reset, flush or cdb_stall is high. Priority order is reset > flush > stall.
- On a grant to index i, at the next posedge:
  - cdb_valid=1; cdb_id, cdb_rob, cdb_data take slice i;
  - last=i; bcast_count increments.
- With no grant, at the next posedge: cdb_valid=0, cdb_id=0, cdb_rob=0, cdb_data=0. The bus is never left stale.
- Handshake: a requester holds req and its payload stable until it sees grant[i]=1 in a cycle. After that posedge it drops req or presents its next result. The requester frees its station when the broadcast appears on the CDB.
- flush: suppresses grant in the cycle it is asserted and forces an idle bus next cycle. It does not alter `last` or bcast_count. Requesters clear their own state.
- bcast_count wraps from 2^CNT_W-1 to 0 without an error indication.

## Timing
- Reset values: cdb_valid=0, cdb_id=0, cdb_rob=0, cdb_data=0, bcast_count=0, last=NUM_REQ-1 (requester 0 highest priority first). grant=0 while reset is high.
- Latency: grant in cycle N; broadcast visible in cycle N+1 for exactly one cycle.
- Throughput: one broadcast per cycle. Back-to-back grants are allowed, to the same requester if it is the only one eligible.
- Simultaneous req on all: grants rotate 0,1,2,0,… with no requester waiting more than NUM_REQ-1 grants.
- Stall mid-stream: any request not granted stays pending. The rotation resumes from the unchanged `last`.
- Reset mid-broadcast: the next cycle is idle and the rotation restarts at requester 0.

## Structure
- The shared package `tomasulo_pkg` holds:
  - TAG_W, ROB_W, DATA_W;
  - tag constants notag=0, add_1..add_3=1..3, mult_1/2=4/5, ld_1..ld_3=6..8, st_1/2=9/10;
  - requester index constants REQ_ADD=0, REQ_MULT=1, REQ_LD=2.
- Sub-module `rr_pick`: combinational rotate-priority picker. Inputs are the eligible vector and `last`; outputs are the one-hot grant and its encoded index.
- Top level: eligibility masking, payload mux, output registers, `last` and counter.

## Test plan
- Reset: assert reset 2 cycles with req=3'b111 → grant=0 throughout; all cdb_* outputs 0; bcast_count=0.
- Single requester: req=3'b010, tag=4, rob=1, data=0xDEAD held → grant=3'b010 in cycle N; cycle N+1 cdb_valid=1, cdb_id=4, cdb_rob=1, cdb_data=0xDEAD; bcast_count=1.
- Fairness: req=3'b111 for 6 cycles with tags 1/4/6 → grants 001,010,100,001,010,100; cdb_id sequence 1,4,6,1,4,6.
- Stall and flush: req=3'b011; cdb_stall high 2 cycles, then flush 1 cycle → no grant and idle bus (cdb_id=0) in each following cycle; first grant after release goes to requester 0 (last unchanged from reset).
- Tag 0 and wrap: req[0]=1 with tag 0 → never granted. Preload bcast_count to 0xFFFF via 65535 broadcasts, then one more grant → bcast_count=0.
